mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/n_bit_two_one_mux.sv | 23 ++
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 440 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared definitions for the memory port arbiter: default bus
//               widths and the arbiter FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    // Default data and address bus widths
    localparam int unsigned C_DEFAULT_N  = 32;
    localparam int unsigned C_DEFAULT_AW = 32;

    // Arbiter FSM states: idle, serving fetch, serving data
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_BUSY_I = 2'd1,
        ST_BUSY_D = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/n_bit_two_one_mux.sv
`default_nettype none
// ============================================================================
// Module      : n_bit_two_one_mux
// Description : Parameterised 2:1 multiplexer.
//   i_a   - selected when i_sel = 0
//   i_b   - selected when i_sel = 1
//   i_sel - select
//   o_y   - result
// Revision    : 1.0 - initial release
// ============================================================================
module n_bit_two_one_mux #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sel,
    output logic [WIDTH-1:0] o_y
);

    assign o_y = i_sel ? i_b : i_a;

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Arbitrates an instruction-fetch port and a load/store data
//               port onto one shared memory port, one transaction at a time.
//   clk, rst                      - clock, synchronous active-high reset
//   if_req/if_addr                - fetch request (level, held until valid)
//   if_rdata/if_valid             - fetch read data and completion pulse
//   d_req/d_we/d_addr/d_wdata     - data request (store when d_we = 1)
//   d_rdata/d_valid               - load data and completion pulse
//   mem_req/mem_we/mem_addr/
//   mem_wdata                     - registered shared memory request
//   mem_rdata/mem_ack             - shared memory read data and completion
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int N  = C_DEFAULT_N,
    parameter int AW = C_DEFAULT_AW
) (
    input  logic          clk,
    input  logic          rst,
    // Fetch port
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [N-1:0]  if_rdata,
    output logic          if_valid,
    // Data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [N-1:0]  d_wdata,
    output logic [N-1:0]  d_rdata,
    output logic          d_valid,
    // Shared memory port
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [N-1:0]  mem_wdata,
    input  logic [N-1:0]  mem_rdata,
    input  logic          mem_ack
);

    arb_state_t    r_state;
    logic          r_last_d;      // previous grant went to data port
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [N-1:0]  r_mem_wdata;
    logic [N-1:0]  r_if_rdata;
    logic [N-1:0]  r_d_rdata;
    logic          r_if_valid;
    logic          r_d_valid;

    logic          w_sel_d;
    logic          w_sel_i;
    logic [AW-1:0] w_grant_addr;
    logic [N-1:0]  w_grant_wdata;

    // Data wins a tie unless it also won the last grant, so neither side can
    // be starved by a continuously requesting neighbour.
    assign w_sel_d = d_req & (~if_req | ~r_last_d);
    assign w_sel_i = if_req & ~w_sel_d;

    n_bit_two_one_mux #(.WIDTH(AW)) u_addr_mux (
        .i_a   (if_addr),
        .i_b   (d_addr),
        .i_sel (w_sel_d),
        .o_y   (w_grant_addr)
    );

    // Fetches never write; their write data is driven as zero.
    n_bit_two_one_mux #(.WIDTH(N)) u_wdata_mux (
        .i_a   ('0),
        .i_b   (d_wdata),
        .i_sel (w_sel_d),
        .o_y   (w_grant_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_last_d    <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rdata  <= '0;
            r_d_rdata   <= '0;
            r_if_valid  <= 1'b0;
            r_d_valid   <= 1'b0;
        end else begin
            // Completion pulses last exactly one cycle
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // mem_ack is ignored here: nothing is outstanding
                    if (w_sel_d || w_sel_i) begin
                        r_state     <= w_sel_d ? ST_BUSY_D : ST_BUSY_I;
                        r_last_d    <= w_sel_d;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_sel_d & d_we;
                        r_mem_addr  <= w_grant_addr;
                        r_mem_wdata <= w_grant_wdata;
                    end
                end
                ST_BUSY_I: begin
                    if (mem_ack) begin
                        r_mem_req  <= 1'b0;
                        r_if_rdata <= mem_rdata;
                        r_if_valid <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                ST_BUSY_D: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        // Stores leave the load data register untouched
                        if (!r_mem_we) begin
                            r_d_rdata <= mem_rdata;
                        end
                        r_d_valid <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rdata  = r_if_rdata;
    assign if_valid  = r_if_valid;
    assign d_rdata   = r_d_rdata;
    assign d_valid   = r_d_valid;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench for mem_port_arbiter. A transaction-level
//               model (requesters, sparse memory, alternating tie-break rule)
//               predicts grants, data and completion pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int N  = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [N-1:0]  if_rdata;
    logic          if_valid;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [N-1:0]  d_wdata = '0;
    logic [N-1:0]  d_rdata;
    logic          d_valid;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [N-1:0]  mem_wdata;
    logic [N-1:0]  mem_rdata = '0;
    logic          mem_ack = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.N(N), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    logic [N-1:0]  mem_model [logic [AW-1:0]];
    bit            auto_ack = 1'b0;
    int            ack_delay = 1;
    bit            rand_delay = 1'b0;
    bit            resp_busy = 1'b0;
    int            resp_cnt = 0;
    bit            resp_owner_d = 1'b0;
    logic [AW-1:0] cap_addr = '0;
    logic          cap_we = 1'b0;
    logic [N-1:0]  cap_wdata = '0;
    logic [N-1:0]  resp_val = '0;
    bit            last_grant_d = 1'b0;
    bit            i_out = 1'b0;
    bit            d_out = 1'b0;
    int            i_policy = 0;   // 0 drop on completion, 1 hold, 2 random
    int            d_policy = 0;
    logic [N-1:0]  exp_if_rdata = '0;
    logic [N-1:0]  exp_d_rdata = '0;
    int            n_if_valid = 0;
    int            n_d_valid = 0;
    bit            order_q[$];     // 1 = data, 0 = fetch, in completion order

    function automatic logic [N-1:0] mem_read(input logic [AW-1:0] a);
        if (mem_model.exists(a)) return mem_model[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        return AW'($urandom_range(0, 15)) << 2;
    endfunction

    // One clock: model of requesters and memory, observed 1 ns after the edge
    task automatic tick();
        bit pi, pd, own_d, ev_i, ev_d;
        logic [AW-1:0] ea;
        logic ew;
        pi = if_req;
        pd = d_req;
        @(posedge clk);
        #1;
        if (if_valid === 1'b1) n_if_valid++;
        if (d_valid === 1'b1) n_d_valid++;
        if (auto_ack) begin
            ev_i = mem_ack && !resp_owner_d;
            ev_d = mem_ack && resp_owner_d;
            n_checks++;
            if (if_valid !== ev_i || d_valid !== ev_d) begin
                n_fail++;
                $display("FAIL valid_pulse: if_valid=%b d_valid=%b, required %b %b", if_valid, d_valid, ev_i, ev_d);
            end
            if (mem_ack) begin
                if (!resp_owner_d) exp_if_rdata = resp_val;
                else if (!cap_we) exp_d_rdata = resp_val;
                if (cap_we) mem_model[cap_addr] = cap_wdata;
                n_checks++;
                if (if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata || mem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL completion: if_rdata=%h d_rdata=%h mem_req=%b, required %h %h 0", if_rdata, d_rdata, mem_req, exp_if_rdata, exp_d_rdata);
                end
                order_q.push_back(resp_owner_d);
                if (resp_owner_d) d_out = 1'b0; else i_out = 1'b0;
                mem_ack = 1'b0;
                resp_busy = 1'b0;
            end
            if (mem_req === 1'b1 && !resp_busy) begin
                // Grant: the owner follows from who was requesting at the edge
                own_d = (pi && pd) ? !last_grant_d : pd;
                last_grant_d = own_d;
                ea = own_d ? d_addr : if_addr;
                ew = own_d ? d_we : 1'b0;
                n_checks++;
                if (!(pi || pd) || mem_addr !== ea || mem_we !== ew || (ew && mem_wdata !== d_wdata)) begin
                    n_fail++;
                    $display("FAIL grant: addr=%h we=%b wdata=%h, required owner_d=%b addr=%h we=%b wdata=%h", mem_addr, mem_we, mem_wdata, own_d, ea, ew, d_wdata);
                end
                resp_busy = 1'b1;
                resp_owner_d = own_d;
                cap_addr = mem_addr;
                cap_we = mem_we;
                cap_wdata = mem_wdata;
                resp_cnt = rand_delay ? int'($urandom_range(1, 4)) : ack_delay;
            end else if (resp_busy) begin
                n_checks++;
                if (mem_req !== 1'b1 || mem_addr !== cap_addr || mem_we !== cap_we || mem_wdata !== cap_wdata) begin
                    n_fail++;
                    $display("FAIL hold: req=%b addr=%h we=%b wdata=%h, required 1 %h %b %h", mem_req, mem_addr, mem_we, mem_wdata, cap_addr, cap_we, cap_wdata);
                end
            end else begin
                n_checks++;
                if (mem_req !== 1'b0) begin
                    n_fail++;
                    $display("FAIL idle_req: mem_req=%b, required 0", mem_req);
                end
            end
            if (resp_busy) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    resp_val = (resp_owner_d && cap_we) ? N'($urandom) : mem_read(cap_addr);
                    mem_rdata = resp_val;
                    mem_ack = 1'b1;
                end
            end
        end
        // Requesters issue new work only once the previous one has completed
        if (!i_out && (i_policy == 1 || (i_policy == 2 && $urandom_range(0, 2) != 0))) begin
            i_out = 1'b1;
            if (i_policy == 2) if_addr = rand_addr();
        end
        if (!d_out && (d_policy == 1 || (d_policy == 2 && $urandom_range(0, 2) != 0))) begin
            d_out = 1'b1;
            if (d_policy == 2) begin
                d_addr = rand_addr();
                d_we = 1'($urandom_range(0, 1));
                d_wdata = N'($urandom);
            end
        end
        if_req = i_out;
        d_req = d_out;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((i_out || d_out || resp_busy) && k < 80) begin
            tick();
            k++;
        end
        n_checks++;
        if (i_out || d_out || resp_busy) begin
            n_fail++;
            $display("FAIL %s_timeout: outstanding i=%0b d=%0b after %0d cycles, required none", tag, i_out, d_out, k);
        end
    endtask

    task automatic do_reset();
        auto_ack = 1'b0;
        i_policy = 0;
        d_policy = 0;
        i_out = 1'b0;
        d_out = 1'b0;
        mem_ack = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        resp_busy = 1'b0;
        last_grant_d = 1'b0;
        exp_if_rdata = '0;
        exp_d_rdata = '0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_mem: req=%b we=%b addr=%h wdata=%h, required all 0", mem_req, mem_we, mem_addr, mem_wdata);
        end
        n_checks++;
        if (if_valid !== 1'b0 || d_valid !== 1'b0 || if_rdata !== '0 || d_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_resp: if_valid=%b d_valid=%b if_rdata=%h d_rdata=%h, required all 0", if_valid, d_valid, if_rdata, d_rdata);
        end
    endtask

    task automatic test_single_fetch();
        int v0;
        auto_ack = 1'b1;
        rand_delay = 1'b0;
        ack_delay = 2;
        mem_model[32'h100] = 32'h0000_0013;
        v0 = n_if_valid;
        if_addr = 32'h100;
        i_out = 1'b1;
        if_req = 1'b1;
        tick();
        n_checks++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_grant: req=%b addr=%h we=%b, required 1 00000100 0", mem_req, mem_addr, mem_we);
        end
        wait_idle("fetch");
        repeat (3) tick();
        n_checks++;
        if (if_rdata !== 32'h13 || n_if_valid - v0 != 1) begin
            n_fail++;
            $display("FAIL fetch_data: if_rdata=%h pulses=%0d, required 00000013 1", if_rdata, n_if_valid - v0);
        end
    endtask

    task automatic test_store();
        int v0;
        auto_ack = 1'b1;
        ack_delay = 1;
        v0 = n_d_valid;
        d_addr = 32'h2000;
        d_we = 1'b1;
        d_wdata = 32'hDEAD_BEEF;
        d_out = 1'b1;
        d_req = 1'b1;
        tick();
        n_checks++;
        if (mem_we !== 1'b1 || mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h2000) begin
            n_fail++;
            $display("FAIL store_grant: we=%b wdata=%h addr=%h, required 1 deadbeef 00002000", mem_we, mem_wdata, mem_addr);
        end
        wait_idle("store");
        tick();
        n_checks++;
        if (d_rdata !== 32'h0 || n_d_valid - v0 != 1) begin
            n_fail++;
            $display("FAIL store_resp: d_rdata=%h pulses=%0d, required 00000000 1", d_rdata, n_d_valid - v0);
        end
        // Read back what was just stored
        d_we = 1'b0;
        d_out = 1'b1;
        d_req = 1'b1;
        wait_idle("load");
        n_checks++;
        if (d_rdata !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL load_back: d_rdata=%h, required deadbeef", d_rdata);
        end
    endtask

    task automatic test_contention();
        int k;
        do_reset();
        auto_ack = 1'b1;
        ack_delay = 1;
        rand_delay = 1'b0;
        order_q.delete();
        if_addr = 32'h300;
        d_addr = 32'h400;
        d_we = 1'b0;
        i_policy = 1;
        d_policy = 1;
        i_out = 1'b1;
        d_out = 1'b1;
        if_req = 1'b1;
        d_req = 1'b1;
        k = 0;
        while (order_q.size() < 4 && k < 60) begin
            tick();
            k++;
        end
        i_policy = 0;
        d_policy = 0;
        wait_idle("contention");
        n_checks++;
        if (order_q.size() < 4 || order_q[0] != 1'b1 || order_q[1] != 1'b0 || order_q[2] != 1'b1 || order_q[3] != 1'b0) begin
            n_fail++;
            $display("FAIL contention_order: got %0d grants starting %p, required D I D I (1 0 1 0)", order_q.size(), order_q);
        end
    endtask

    task automatic test_wait_states();
        int v0;
        auto_ack = 1'b1;
        rand_delay = 1'b0;
        ack_delay = 5;
        v0 = n_d_valid;
        d_addr = 32'h0000_0A0C;
        d_we = 1'b1;
        d_wdata = 32'h1234_5678;
        d_out = 1'b1;
        d_req = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h0000_0A0C || mem_we !== 1'b1 || mem_wdata !== 32'h1234_5678) begin
                n_fail++;
                $display("FAIL wait_hold_%0d: req=%b addr=%h we=%b wdata=%h, required 1 00000a0c 1 12345678", c, mem_req, mem_addr, mem_we, mem_wdata);
            end
            if (c < 4) tick();
        end
        wait_idle("wait_states");
        repeat (2) tick();
        n_checks++;
        if (n_d_valid - v0 != 1) begin
            n_fail++;
            $display("FAIL wait_pulses: d_valid pulses=%0d, required 1", n_d_valid - v0);
        end
        ack_delay = 1;
    endtask

    task automatic test_reset_mid();
        auto_ack = 1'b0;
        d_addr = 32'h40;
        d_we = 1'b0;
        d_out = 1'b1;
        d_req = 1'b1;
        tick();
        n_checks++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL rmid_grant: mem_req=%b, required 1", mem_req);
        end
        tick();
        rst = 1'b1;
        d_out = 1'b0;
        d_req = 1'b0;
        tick();
        rst = 1'b0;
        mem_rdata = 32'hCAFE_F00D;
        mem_ack = 1'b1;
        tick();
        n_checks++;
        if (d_valid !== 1'b0 || mem_req !== 1'b0 || d_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rmid_ack: d_valid=%b mem_req=%b d_rdata=%h, required 0 0 00000000", d_valid, mem_req, d_rdata);
        end
        mem_ack = 1'b0;
        tick();
        n_checks++;
        if (d_valid !== 1'b0 || if_valid !== 1'b0 || mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_after: d_valid=%b if_valid=%b mem_req=%b, required 0 0 0", d_valid, if_valid, mem_req);
        end
        resp_busy = 1'b0;
        last_grant_d = 1'b0;
        exp_if_rdata = '0;
        exp_d_rdata = '0;
        // Port must be usable again
        auto_ack = 1'b1;
        if_addr = 32'h100;
        i_out = 1'b1;
        if_req = 1'b1;
        wait_idle("rmid_fetch");
    endtask

    task automatic test_random();
        auto_ack = 1'b1;
        rand_delay = 1'b1;
        i_policy = 2;
        d_policy = 2;
        repeat (400) tick();
        i_policy = 0;
        d_policy = 0;
        wait_idle("random");
        rand_delay = 1'b0;
    endtask

    task automatic test_spurious_ack();
        auto_ack = 1'b0;
        tick();
        mem_rdata = 32'hFFFF_FFFF;
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (if_rdata !== exp_if_rdata || d_rdata !== exp_d_rdata || if_valid !== 1'b0 || d_valid !== 1'b0 || mem_req !== 1'b0) begin
                n_fail++;
                $display("FAIL spurious_%0d: if_rdata=%h d_rdata=%h valids=%b%b req=%b, required %h %h 00 0", c, if_rdata, d_rdata, if_valid, d_valid, mem_req, exp_if_rdata, exp_d_rdata);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_contention();
        test_wait_states();
        test_reset_mid();
        test_random();
        test_spurious_ack();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
